flash_bus_arbiter: RTL and testbench



---
 rtl/flash_bus_arbiter_if.sv | 45 ++++
 rtl/flash_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_flash_bus_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/flash_bus_arbiter_if.sv
// rtl/flash_bus_arbiter_if.sv - two requester ports plus byte-serial flash bus shared by flash_bus_arbiter
interface flash_bus_arbiter_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] p0_addr;
    logic [XLEN-1:0] p1_addr;
    logic            p0_read;
    logic            p1_read;
    logic            p0_write;
    logic            p1_write;
    logic [XLEN-1:0] p0_wdata;
    logic [XLEN-1:0] p1_wdata;
    logic [1:0]      p0_byte_size;
    logic [1:0]      p1_byte_size;
    logic [XLEN-1:0] p0_rdata;
    logic [XLEN-1:0] p1_rdata;
    logic            p0_ready;
    logic            p1_ready;
    logic            grant_id;
    logic            busy;
    logic [XLEN-1:0] digital_flash_addr;
    logic            digital_flash_read_en;
    logic            digital_flash_write_en;
    logic [2:0]      digital_flash_byte_size;
    logic [7:0]      digital_flash_wdata;
    logic [7:0]      digital_flash_data;

    modport slave (
        input  p0_addr, p1_addr, p0_read, p1_read, p0_write, p1_write,
        input  p0_wdata, p1_wdata, p0_byte_size, p1_byte_size,
        output p0_rdata, p1_rdata, p0_ready, p1_ready, grant_id, busy,
        output digital_flash_addr, digital_flash_read_en, digital_flash_write_en,
        output digital_flash_byte_size, digital_flash_wdata,
        input  digital_flash_data
    );

    modport master (
        output p0_addr, p1_addr, p0_read, p1_read, p0_write, p1_write,
        output p0_wdata, p1_wdata, p0_byte_size, p1_byte_size,
        input  p0_rdata, p1_rdata, p0_ready, p1_ready, grant_id, busy,
        input  digital_flash_addr, digital_flash_read_en, digital_flash_write_en,
        input  digital_flash_byte_size, digital_flash_wdata,
        output digital_flash_data
    );
endinterface

// File: rtl/flash_bus_arbiter.sv
// rtl/flash_bus_arbiter.sv - two-port word arbiter over a byte-serial flash; FLASH_ARB_ROUND_ROBIN_EN selects alternating tie-break
module flash_bus_arbiter #(
    parameter int XLEN = 32
) (
    input  logic                  flashclk,
    input  logic                  rst,
    flash_bus_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [XLEN-1:0] ADDR_STEP = {{(XLEN-1){1'b0}}, 1'b1};

    state_t          state_q;
    logic [1:0]      cnt_q;
    logic [1:0]      last_idx_q;
    logic            is_read_q;
    logic            grant_id_q;
    logic            busy_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wsh_q;
    logic [XLEN-1:0] shadow_q;
    logic [XLEN-1:0] shadow_d;
    logic [XLEN-1:0] p0_rdata_q;
    logic [XLEN-1:0] p1_rdata_q;
    logic            p0_ready_q;
    logic            p1_ready_q;
    logic            read_en_q;
    logic            write_en_q;
    logic [7:0]      wdata_q;
`ifdef FLASH_ARB_ROUND_ROBIN_EN
    logic            last_grant_q;
`endif

    logic            req0;
    logic            req1;
    logic            req_granted;
    logic            win;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;
    logic [1:0]      sel_size;
    logic            sel_read;

    assign req0        = bus.p0_read | bus.p0_write;
    assign req1        = bus.p1_read | bus.p1_write;
    assign req_granted = grant_id_q ? req1 : req0;

    always_comb begin
        win = req1 & ~req0;
`ifdef FLASH_ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            win = ~last_grant_q;
        end
`endif
    end

    assign sel_addr  = win ? bus.p1_addr      : bus.p0_addr;
    assign sel_wdata = win ? bus.p1_wdata     : bus.p0_wdata;
    assign sel_size  = win ? bus.p1_byte_size : bus.p0_byte_size;
    assign sel_read  = win ? bus.p1_read      : bus.p0_read;

    // Shadow word with the byte currently on the flash bus merged in.
    always_comb begin
        shadow_d = shadow_q;
        shadow_d[{cnt_q, 3'b000} +: 8] = bus.digital_flash_data;
    end

    always_ff @(posedge flashclk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            last_idx_q   <= 2'd0;
            is_read_q    <= 1'b0;
            grant_id_q   <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= '0;
            wsh_q        <= '0;
            shadow_q     <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            p0_ready_q   <= 1'b0;
            p1_ready_q   <= 1'b0;
            read_en_q    <= 1'b0;
            write_en_q   <= 1'b0;
            wdata_q      <= 8'd0;
`ifdef FLASH_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_id_q <= win;
                        busy_q     <= 1'b1;
                        addr_q     <= sel_addr;
                        is_read_q  <= sel_read;
                        read_en_q  <= sel_read;
                        write_en_q <= ~sel_read;
                        wdata_q    <= sel_wdata[7:0];
                        wsh_q      <= sel_wdata >> 8;
                        // size 0 wraps to index 3, i.e. a full 4-byte word
                        last_idx_q <= sel_size - 2'd1;
                        cnt_q      <= 2'd0;
                        shadow_q   <= '0;
                        state_q    <= XFER;
                    end
                end
                XFER: begin
                    if (!req_granted) begin
                        read_en_q  <= 1'b0;
                        write_en_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        if (is_read_q) begin
                            shadow_q <= shadow_d;
                        end
                        if (cnt_q == last_idx_q) begin
                            read_en_q  <= 1'b0;
                            write_en_q <= 1'b0;
                            state_q    <= DONE;
                            if (grant_id_q) begin
                                p1_ready_q <= 1'b1;
                                if (is_read_q) p1_rdata_q <= shadow_d;
                            end else begin
                                p0_ready_q <= 1'b1;
                                if (is_read_q) p0_rdata_q <= shadow_d;
                            end
                        end else begin
                            cnt_q   <= cnt_q + 2'd1;
                            addr_q  <= addr_q + ADDR_STEP;
                            wdata_q <= wsh_q[7:0];
                            wsh_q   <= wsh_q >> 8;
                        end
                    end
                end
                DONE: begin
                    p0_ready_q   <= 1'b0;
                    p1_ready_q   <= 1'b0;
                    busy_q       <= 1'b0;
`ifdef FLASH_ARB_ROUND_ROBIN_EN
                    last_grant_q <= grant_id_q;
`endif
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.p0_rdata                = p0_rdata_q;
    assign bus.p1_rdata                = p1_rdata_q;
    assign bus.p0_ready                = p0_ready_q;
    assign bus.p1_ready                = p1_ready_q;
    assign bus.grant_id                = grant_id_q;
    assign bus.busy                    = busy_q;
    assign bus.digital_flash_addr      = addr_q;
    assign bus.digital_flash_read_en   = read_en_q;
    assign bus.digital_flash_write_en  = write_en_q;
    assign bus.digital_flash_byte_size = 3'b111;
    assign bus.digital_flash_wdata     = wdata_q;
endmodule

// File: tb/tb_flash_bus_arbiter.sv
// tb/tb_flash_bus_arbiter.sv - directed self-checking bench for flash_bus_arbiter
module tb_flash_bus_arbiter;
    logic flashclk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

`ifdef FLASH_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    flash_bus_arbiter_if #(.XLEN(32)) bus ();

    flash_bus_arbiter #(.XLEN(32)) dut (
        .flashclk (flashclk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 flashclk = ~flashclk;

    function automatic logic [7:0] fmem(input logic [31:0] a);
        case (a)
            32'h0000_0100: fmem = 8'h11;
            32'h0000_0101: fmem = 8'h22;
            32'h0000_0102: fmem = 8'h33;
            32'h0000_0103: fmem = 8'h44;
            32'hFFFF_FFFF: fmem = 8'h5A;
            default:       fmem = a[7:0] + 8'h01;
        endcase
    endfunction

    assign bus.digital_flash_data = fmem(bus.digital_flash_addr);

    task automatic tick();
        @(posedge flashclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.p0_addr = '0;  bus.p1_addr = '0;
        bus.p0_read = 1'b0; bus.p1_read = 1'b0;
        bus.p0_write = 1'b0; bus.p1_write = 1'b0;
        bus.p0_wdata = '0; bus.p1_wdata = '0;
        bus.p0_byte_size = 2'd0; bus.p1_byte_size = 2'd0;
        repeat (2) tick();

        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_rd_en", 32'(bus.digital_flash_read_en), 32'd0);
        check("rst_wr_en", 32'(bus.digital_flash_write_en), 32'd0);
        check("rst_bsize", 32'(bus.digital_flash_byte_size), 32'd7);
        check("rst_addr",  bus.digital_flash_addr, 32'd0);
        check("rst_rdata", bus.p0_rdata, 32'd0);
        check("rst_ready", 32'({bus.p0_ready, bus.p1_ready}), 32'd0);
        rst = 1'b1;
        tick();

        // Port 0, 4-byte read at 0x100
        bus.p0_addr = 32'h100; bus.p0_read = 1'b1; bus.p0_byte_size = 2'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_addr",  bus.digital_flash_addr, 32'h100 + 32'(k));
            check("t1_rd_en", 32'(bus.digital_flash_read_en), 32'd1);
            check("t1_ready", 32'(bus.p0_ready), 32'd0);
        end
        tick();
        check("t1_done_ready", 32'(bus.p0_ready), 32'd1);
        check("t1_done_rd_en", 32'(bus.digital_flash_read_en), 32'd0);
        check("t1_rdata",      bus.p0_rdata, 32'h4433_2211);
        check("t1_done_busy",  32'(bus.busy), 32'd1);
        tick();
        bus.p0_read = 1'b0;
        check("t1_idle_ready", 32'(bus.p0_ready), 32'd0);
        check("t1_idle_busy",  32'(bus.busy), 32'd0);
        tick();

        // Port 1, 2-byte write at 0x20
        bus.p1_addr = 32'h20; bus.p1_write = 1'b1; bus.p1_wdata = 32'hAABB_CCDD; bus.p1_byte_size = 2'd2;
        tick();
        check("t2_wr_en0", 32'(bus.digital_flash_write_en), 32'd1);
        check("t2_rd_en0", 32'(bus.digital_flash_read_en), 32'd0);
        check("t2_addr0",  bus.digital_flash_addr, 32'h20);
        check("t2_wdata0", 32'(bus.digital_flash_wdata), 32'hDD);
        check("t2_grant",  32'(bus.grant_id), 32'd1);
        tick();
        check("t2_wr_en1", 32'(bus.digital_flash_write_en), 32'd1);
        check("t2_addr1",  bus.digital_flash_addr, 32'h21);
        check("t2_wdata1", 32'(bus.digital_flash_wdata), 32'hCC);
        tick();
        check("t2_wr_en_done", 32'(bus.digital_flash_write_en), 32'd0);
        check("t2_p1_ready",   32'(bus.p1_ready), 32'd1);
        check("t2_p0_ready",   32'(bus.p0_ready), 32'd0);
        check("t2_p1_rdata",   bus.p1_rdata, 32'd0);
        tick();
        bus.p1_write = 1'b0;
        check("t2_no_third",   32'(bus.digital_flash_write_en), 32'd0);
        check("t2_ready_drop", 32'(bus.p1_ready), 32'd0);
        tick();

        // Continuous tie of 4-byte reads
        bus.p0_addr = 32'h100; bus.p0_read = 1'b1; bus.p0_byte_size = 2'd0;
        bus.p1_addr = 32'h200; bus.p1_read = 1'b1; bus.p1_byte_size = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_grant", 32'(bus.grant_id), RR ? 32'(i % 2) : 32'd0);
            repeat (5) tick();
        end
        bus.p0_read = 1'b0; bus.p1_read = 1'b0;
        check("t3_p1_rdata", bus.p1_rdata, RR ? 32'h0403_0201 : 32'd0);
        check("t3_p0_rdata", bus.p0_rdata, 32'h4433_2211);
        tick();
        check("t3_idle_busy", 32'(bus.busy), 32'd0);
        tick();

        // Port 0 aborts after two bytes while port 1 waits
        bus.p0_addr = 32'h300; bus.p0_read = 1'b1; bus.p0_byte_size = 2'd0;
        bus.p1_addr = 32'h40;  bus.p1_read = 1'b1; bus.p1_byte_size = 2'd1;
        tick();
        check("t4_grant0", 32'(bus.grant_id), 32'd0);
        check("t4_addr0",  bus.digital_flash_addr, 32'h300);
        tick();
        tick();
        bus.p0_read = 1'b0;
        check("t4_addr2",  bus.digital_flash_addr, 32'h302);
        tick();
        check("t4_abort_rd_en", 32'(bus.digital_flash_read_en), 32'd0);
        check("t4_abort_busy",  32'(bus.busy), 32'd0);
        check("t4_abort_ready", 32'(bus.p0_ready), 32'd0);
        tick();
        check("t4_grant1", 32'(bus.grant_id), 32'd1);
        check("t4_addr1",  bus.digital_flash_addr, 32'h40);
        check("t4_rd_en1", 32'(bus.digital_flash_read_en), 32'd1);
        tick();
        check("t4_p1_ready", 32'(bus.p1_ready), 32'd1);
        check("t4_p1_rdata", bus.p1_rdata, 32'h0000_0041);
        check("t4_p0_held",  bus.p0_rdata, 32'h4433_2211);
        check("t4_p0_ready", 32'(bus.p0_ready), 32'd0);
        tick();
        bus.p1_read = 1'b0;
        tick();

        // Reset in third XFER cycle, then port 0 wins the tie
        bus.p0_addr = 32'h100; bus.p0_read = 1'b1; bus.p0_byte_size = 2'd0;
        bus.p1_addr = 32'h200; bus.p1_read = 1'b1; bus.p1_byte_size = 2'd0;
        tick();
        check("t5_grant", 32'(bus.grant_id), 32'd0);
        tick();
        tick();
        check("t5_pre_rd_en", 32'(bus.digital_flash_read_en), 32'd1);
        rst = 1'b0;
        #1;
        check("t5_rst_rd_en", 32'(bus.digital_flash_read_en), 32'd0);
        check("t5_rst_busy",  32'(bus.busy), 32'd0);
        check("t5_rst_ready", 32'({bus.p0_ready, bus.p1_ready}), 32'd0);
        check("t5_rst_rdata", bus.p0_rdata, 32'd0);
        #2;
        rst = 1'b1;
        tick();
        check("t5_regrant", 32'(bus.grant_id), 32'd0);
        check("t5_busy",    32'(bus.busy), 32'd1);
        check("t5_addr",    bus.digital_flash_addr, 32'h100);
        bus.p0_read = 1'b0; bus.p1_read = 1'b0;
        tick();
        check("t5_abort_busy", 32'(bus.busy), 32'd0);
        tick();

        // Single-byte read at the top of the address space, write ignored
        bus.p0_addr = 32'hFFFF_FFFF; bus.p0_read = 1'b1; bus.p0_write = 1'b1;
        bus.p0_wdata = 32'hDEAD_BEEF; bus.p0_byte_size = 2'd1;
        tick();
        check("t6_addr",  bus.digital_flash_addr, 32'hFFFF_FFFF);
        check("t6_rd_en", 32'(bus.digital_flash_read_en), 32'd1);
        check("t6_wr_en", 32'(bus.digital_flash_write_en), 32'd0);
        tick();
        check("t6_rd_en_done", 32'(bus.digital_flash_read_en), 32'd0);
        check("t6_ready",      32'(bus.p0_ready), 32'd1);
        check("t6_rdata",      bus.p0_rdata, 32'h0000_005A);
        tick();
        bus.p0_read = 1'b0; bus.p0_write = 1'b0;
        check("t6_idle_busy",  32'(bus.busy), 32'd0);
        check("t6_idle_rd_en", 32'(bus.digital_flash_read_en), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
